matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
- Loop sequencer for an N x N matrix multiply, C = A x B.
- Walks the i, j and k indices and generates the A, B and C word addresses.
- Drives the accumulator register's clear and accumulate strobes, and the C write-enable.
- Sits between the top-level start/done handshake and the memory/MAC datapath. Does no arithmetic on data words.

Parameters:
- word_size, 16: width of the address outputs; all address arithmetic is modulo 2^word_size.
- dim_width, 8: width of the matrix dimension and of the i, j and k indices.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin; sampled only in IDLE.
- n_dim  in  dim_width  matrix dimension N; latched when start is accepted.
- stall  in  1  datapath not ready; freezes sequencing in MAC and WRITE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  out  1  one-cycle completion pulse.
- acc_clr  out  1  clears the accumulator (drives its rst).
- mac_en  out  1  accumulate the current A[i][k]*B[k][j] product.
- c_we  out  1  write the accumulator to C[i][j].
- addr_a  out  word_size  i*N + k.
- addr_b  out  word_size  k*N + j.
- addr_c  out  word_size  i*N + j.
- i_idx, j_idx, k_idx  out  dim_width each  current loop indices.

Behaviour:
- Reset: rst=1 at a clock edge forces IDLE and clears every output and internal register to 0. This applies mid-operation too: there is no done pulse and no c_we. rst has priority over every other input.
- States: IDLE, CLEAR, MAC, WRITE, DONE.
- IDLE:
  - start=1 latches N.
  - N>0: next state is CLEAR with i=j=k=0.
  - N=0: next state is DONE directly, with no strobes.
  - start while not in IDLE is ignored; it is not queued.
- CLEAR:
  - Lasts 1 cycle with acc_clr=1.
  - Sets k=0, addr_a=i*N and addr_b=j.
  - Next state is MAC. stall is ignored here.
- MAC:
  - mac_en=1 whenever stall=0.
  - Each non-stalled cycle: k+1, addr_a+1, addr_b+N.
  - When k=N-1 and stall=0, next state is WRITE.
  - stall=1: mac_en=0 and all indices and addresses hold.
- WRITE:
  - c_we = !stall.
  - On the non-stalled cycle: if j<N-1, j+1 and go to CLEAR.
  - Otherwise j=0; then if i<N-1, i+1 and go to CLEAR, else go to DONE.
- DONE:
  - 1 cycle with done=1 and busy=1.
  - Next state is IDLE. Indices return to 0.
- Addressing:
  - addr_c = i*N + j, maintained incrementally: +1 per WRITE.
  - No multipliers are used. Offsets are added in word_size bits and wrap silently.
- Latency with no stalls:
  - start is sampled at edge 0, so CLEAR occupies cycle 1.
  - done is high in cycle 1 + N^2(N+2). For N=1 that is cycle 4; for N=2 it is cycle 17.
  - Each stalled cycle adds exactly 1 cycle.
- Strobe exclusivity: acc_clr, mac_en and c_we are mutually exclusive in every cycle.
- Boundary values:
  - N=1: a single MAC cycle per element.
  - N=2^dim_width-1: the indices must not overflow; the terminal compare is against N-1.

Decomposition:
- Package matmul_pkg holds:
  - the state enum (IDLE, CLEAR, MAC, WRITE, DONE);
  - localparams for default word_size and dim_width;
  - a function computing the expected cycle count, for bench use.
- Sub-module idx_counter, instantiated three times (i, j, k):
  - Inputs: clr and inc; parameter: width.
  - Input: limit. Output: at_last (value==limit-1).
  - Behaviour: wraps to 0 on inc when at_last.

Test Plan:
- Basic run, no stalls: rst for 2 cycles, then start with n_dim=2 and stall=0.
  - Expect 4 c_we pulses with addr_c = 0, 1, 2, 3.
  - Expect MAC addr_a/addr_b sequence for C[0][1]: (0,1), (1,3).
  - Expect done in cycle 17 with busy high for cycles 1-17.
- N=1: start with n_dim=1.
  - Expect the sequence acc_clr, mac_en (addr_a=0, addr_b=0), c_we (addr_c=0), done in cycle 4.
- N=0: start with n_dim=0.
  - Expect no acc_clr, mac_en or c_we; done in cycle 1; back to IDLE in cycle 2.
- Stalls: n_dim=2 with stall=1 for 3 cycles during the second MAC cycle of element 0 and for 1 cycle in its WRITE.
  - Expect mac_en and c_we low and indices/addresses frozen during the stalls.
  - Expect done in cycle 21.
- Reset mid-operation and start while busy:
  - Pulse start during MAC: expect it to be ignored.
  - Assert rst at cycle 6 of an n_dim=3 run: expect all outputs 0 the next cycle, no done, and a clean restart on the next start.
- Wrap: word_size=4, n_dim=5.
  - Expect addr_b (k*N + j) to wrap modulo 16, e.g. k=4, j=0 gives 20 mod 16 = 4.
  - Expect indices to stay below 5 and done at 1 + 25*7 = 176.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply loop sequencer.
//   - state_e         : sequencer FSM states
//   - DefWordSize     : default address width
//   - DefDimWidth     : default dimension / index width
//   - expected_cycles : cycle in which done pulses for a stall-free run of dimension n,
//                       counting the cycle after start is accepted as cycle 1
package matmul_pkg;

  localparam int unsigned DefWordSize = 16;
  localparam int unsigned DefDimWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMac,
    StWrite,
    StDone
  } state_e;

  // One CLEAR, n MAC and one WRITE cycle per element, plus the DONE cycle.
  function automatic int unsigned expected_cycles(input int unsigned n);
    if (n == 0) return 1;
    return 1 + n * n * (n + 2);
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_idx_counter.sv
// Loop index counter with programmable terminal value.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   clr_i     : force value to 0 (priority over inc_i)
//   inc_i     : advance value, wrapping to 0 after limit_i-1
//   limit_i   : loop trip count
//   value_o   : current index
//   at_last_o : value_o == limit_i - 1
module idx_counter
  import matmul_pkg::*;
#(
  parameter int unsigned Width = DefDimWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] value_o,
  output logic             at_last_o
);

  logic [Width-1:0] value_q, value_d;

  // Compare against limit-1 so a limit of 2^Width-1 never needs a Width+1 bit value.
  assign at_last_o = (value_q == (limit_i - Width'(1)));
  assign value_o   = value_q;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i) begin
      value_d = at_last_o ? '0 : (value_q + Width'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Loop sequencer for an N x N matrix multiply C = A x B.
// Walks i/j/k, generates A/B/C word addresses and the accumulator strobes.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, priority over everything
//   start_i    : one-cycle start request, honoured only in idle
//   n_dim_i    : matrix dimension, latched on an accepted start
//   stall_i    : datapath not ready; freezes MAC and WRITE
//   busy_o     : high from the cycle after start through the done cycle
//   done_o     : one-cycle completion pulse
//   acc_clr_o  : clear the accumulator
//   mac_en_o   : accumulate A[i][k]*B[k][j]
//   c_we_o     : write the accumulator to C[i][j]
//   addr_a_o   : i*N + k
//   addr_b_o   : k*N + j
//   addr_c_o   : i*N + j
//   i/j/k_idx_o: current loop indices
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned WordSize = DefWordSize,
  parameter int unsigned DimWidth = DefDimWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [DimWidth-1:0] n_dim_i,
  input  logic                stall_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                acc_clr_o,
  output logic                mac_en_o,
  output logic                c_we_o,
  output logic [WordSize-1:0] addr_a_o,
  output logic [WordSize-1:0] addr_b_o,
  output logic [WordSize-1:0] addr_c_o,
  output logic [DimWidth-1:0] i_idx_o,
  output logic [DimWidth-1:0] j_idx_o,
  output logic [DimWidth-1:0] k_idx_o
);

  state_e              state_q;
  logic [DimWidth-1:0] n_q;
  logic                busy_q;
  logic                done_q;
  logic                acc_clr_q;
  logic [WordSize-1:0] addr_a_q;
  logic [WordSize-1:0] addr_b_q;
  logic [WordSize-1:0] addr_c_q;
  // i*N kept incrementally so CLEAR can reload addr_a without a multiplier.
  logic [WordSize-1:0] row_base_q;

  logic                start_ok;
  logic                k_clr, k_inc, k_last;
  logic                j_clr, j_inc, j_last;
  logic                i_clr, i_inc, i_last;
  logic [WordSize-1:0] n_word;
  logic [WordSize-1:0] j_word;

  assign start_ok = (state_q == StIdle) && start_i;
  assign n_word   = WordSize'(n_q);
  assign j_word   = WordSize'(j_idx_o);

  // Counter controls derive from the current state, so the counters move on the
  // same edge as the FSM transition that consumes them.
  assign k_clr = start_ok || (state_q == StClear) || (state_q == StDone);
  assign k_inc = (state_q == StMac) && !stall_i;
  assign j_clr = start_ok || (state_q == StDone);
  assign j_inc = (state_q == StWrite) && !stall_i;
  assign i_clr = j_clr;
  assign i_inc = j_inc && j_last;

  idx_counter #(
    .Width (DimWidth)
  ) u_k_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (k_clr),
    .inc_i     (k_inc),
    .limit_i   (n_q),
    .value_o   (k_idx_o),
    .at_last_o (k_last)
  );

  idx_counter #(
    .Width (DimWidth)
  ) u_j_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (j_clr),
    .inc_i     (j_inc),
    .limit_i   (n_q),
    .value_o   (j_idx_o),
    .at_last_o (j_last)
  );

  idx_counter #(
    .Width (DimWidth)
  ) u_i_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (i_clr),
    .inc_i     (i_inc),
    .limit_i   (n_q),
    .value_o   (i_idx_o),
    .at_last_o (i_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      n_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_clr_q  <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_c_q   <= '0;
      row_base_q <= '0;
    end else begin
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            n_q        <= n_dim_i;
            busy_q     <= 1'b1;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_c_q   <= '0;
            row_base_q <= '0;
            if (n_dim_i != '0) begin
              state_q   <= StClear;
              acc_clr_q <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StClear: begin
          addr_a_q <= row_base_q;
          addr_b_q <= j_word;
          state_q  <= StMac;
        end
        StMac: begin
          if (!stall_i) begin
            addr_a_q <= addr_a_q + WordSize'(1);
            addr_b_q <= addr_b_q + n_word;
            if (k_last) begin
              state_q <= StWrite;
            end
          end
        end
        StWrite: begin
          if (!stall_i) begin
            addr_c_q <= addr_c_q + WordSize'(1);
            if (j_last && i_last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              if (j_last) begin
                row_base_q <= row_base_q + n_word;
              end
              state_q   <= StClear;
              acc_clr_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          addr_a_q   <= '0;
          addr_b_q   <= '0;
          addr_c_q   <= '0;
          row_base_q <= '0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // MAC/WRITE strobes must drop in the very cycle stall rises, so they are
  // gated by stall_i on top of the registered state.
  assign mac_en_o  = (state_q == StMac) && !stall_i;
  assign c_we_o    = (state_q == StWrite) && !stall_i;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign acc_clr_o = acc_clr_q;
  assign addr_a_o  = addr_a_q;
  assign addr_b_o  = addr_b_q;
  assign addr_c_o  = addr_c_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl. Cycle 1 is the cycle after the edge that samples start.
module tb_matmul_seq_ctrl;
  import matmul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  n_dim = '0;
  logic        busy, done, acc_clr, mac_en, c_we;
  logic [15:0] addr_a, addr_b, addr_c;
  logic [7:0]  i_idx, j_idx, k_idx;

  logic        w_start = 1'b0;
  logic        w_stall = 1'b0;
  logic [7:0]  w_n_dim = '0;
  logic        w_busy, w_done, w_acc_clr, w_mac_en, w_c_we;
  logic [3:0]  w_addr_a, w_addr_b, w_addr_c;
  logic [7:0]  w_i_idx, w_j_idx, w_k_idx;

  int checks = 0;
  int fails  = 0;

  matmul_seq_ctrl #(.WordSize(16), .DimWidth(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .n_dim_i(n_dim), .stall_i(stall),
    .busy_o(busy), .done_o(done), .acc_clr_o(acc_clr), .mac_en_o(mac_en), .c_we_o(c_we),
    .addr_a_o(addr_a), .addr_b_o(addr_b), .addr_c_o(addr_c),
    .i_idx_o(i_idx), .j_idx_o(j_idx), .k_idx_o(k_idx)
  );

  matmul_seq_ctrl #(.WordSize(4), .DimWidth(8)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(w_start), .n_dim_i(w_n_dim), .stall_i(w_stall),
    .busy_o(w_busy), .done_o(w_done), .acc_clr_o(w_acc_clr), .mac_en_o(w_mac_en),
    .c_we_o(w_c_we), .addr_a_o(w_addr_a), .addr_b_o(w_addr_b), .addr_c_o(w_addr_c),
    .i_idx_o(w_i_idx), .j_idx_o(w_j_idx), .k_idx_o(w_k_idx)
  );

  // Per-cycle log of the last run, indexed by cycle number.
  logic        busy_l[64], done_l[64], clr_l[64], mac_l[64], we_l[64];
  logic [15:0] a_l[64], b_l[64], c_l[64];
  logic [7:0]  i_l[64], j_l[64], k_l[64];
  logic [15:0] mac_a[32], mac_b[32], we_addr[32];
  int          mac_n, we_n, clr_n, done_cnt, done_at, overlap;

  task automatic run(input logic [7:0] n, input logic [63:0] stall_mask, input int start_again,
                     input int rst_at, input int ncyc);
    mac_n = 0; we_n = 0; clr_n = 0; done_cnt = 0; done_at = -1; overlap = 0;
    for (int c = 0; c < 64; c++) begin
      busy_l[c] = 0; done_l[c] = 0; clr_l[c] = 0; mac_l[c] = 0; we_l[c] = 0;
      a_l[c] = '0; b_l[c] = '0; c_l[c] = '0; i_l[c] = '0; j_l[c] = '0; k_l[c] = '0;
    end
    n_dim = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      stall = stall_mask[c];
      start = (c == start_again);
      rst   = (c == rst_at);
      @(negedge clk);
      busy_l[c] = busy; done_l[c] = done; clr_l[c] = acc_clr; mac_l[c] = mac_en; we_l[c] = c_we;
      a_l[c] = addr_a; b_l[c] = addr_b; c_l[c] = addr_c;
      i_l[c] = i_idx; j_l[c] = j_idx; k_l[c] = k_idx;
      if (done) begin done_cnt++; done_at = c; end
      if (acc_clr) clr_n++;
      if (mac_en && mac_n < 32) begin mac_a[mac_n] = addr_a; mac_b[mac_n] = addr_b; mac_n++; end
      if (c_we && we_n < 32) begin we_addr[we_n] = addr_c; we_n++; end
      if (int'(acc_clr) + int'(mac_en) + int'(c_we) > 1) overlap++;
      @(posedge clk); #1;
    end
    stall = 1'b0; start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, acc_clr, mac_en, c_we, w_busy, w_done} !== 7'b0) begin
      fails++; $display("FAIL reset_strobes: got %b expected 0",
                        {busy, done, acc_clr, mac_en, c_we, w_busy, w_done});
    end
    checks++;
    if ({addr_a, addr_b, addr_c} !== 48'h0) begin
      fails++; $display("FAIL reset_addrs: got %h expected 0", {addr_a, addr_b, addr_c});
    end
    checks++;
    if ({i_idx, j_idx, k_idx} !== 24'h0) begin
      fails++; $display("FAIL reset_idx: got %h expected 0", {i_idx, j_idx, k_idx});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] exp_a[8];
    logic [15:0] exp_b[8];
    exp_a = '{0, 1, 0, 1, 2, 3, 2, 3};
    exp_b = '{0, 2, 1, 3, 0, 2, 1, 3};
    run(8'd2, 64'h0, 0, 0, 20);
    checks++;
    if (done_at !== 17) begin fails++; $display("FAIL basic_done_cycle: got %0d expected 17", done_at); end
    checks++;
    if (done_cnt !== 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (we_n !== 4) begin fails++; $display("FAIL basic_we_count: got %0d expected 4", we_n); end
    for (int e = 0; e < 4 && e < we_n; e++) begin
      checks++;
      if (we_addr[e] !== 16'(e)) begin
        fails++; $display("FAIL basic_addr_c[%0d]: got %0d expected %0d", e, we_addr[e], e);
      end
    end
    checks++;
    if (mac_n !== 8) begin fails++; $display("FAIL basic_mac_count: got %0d expected 8", mac_n); end
    for (int m = 0; m < 8 && m < mac_n; m++) begin
      checks++;
      if ({mac_a[m], mac_b[m]} !== {exp_a[m], exp_b[m]}) begin
        fails++; $display("FAIL basic_mac_addr[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                          m, mac_a[m], mac_b[m], exp_a[m], exp_b[m]);
      end
    end
    checks++;
    if (clr_n !== 4) begin fails++; $display("FAIL basic_clr_count: got %0d expected 4", clr_n); end
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (busy_l[c] !== (c <= 17)) begin
        fails++; $display("FAIL basic_busy[%0d]: got %b expected %b", c, busy_l[c], (c <= 17));
      end
    end
    checks++;
    if (overlap !== 0) begin fails++; $display("FAIL basic_strobe_excl: got %0d expected 0", overlap); end
  endtask

  task automatic test_n1();
    run(8'd1, 64'h0, 0, 0, 8);
    checks++;
    if ({clr_l[1], mac_l[1], we_l[1]} !== 3'b100) begin
      fails++; $display("FAIL n1_cycle1: got %b expected 100", {clr_l[1], mac_l[1], we_l[1]});
    end
    checks++;
    if ({mac_l[2], a_l[2], b_l[2]} !== {1'b1, 16'd0, 16'd0}) begin
      fails++; $display("FAIL n1_mac: got en=%b a=%0d b=%0d expected en=1 a=0 b=0",
                        mac_l[2], a_l[2], b_l[2]);
    end
    checks++;
    if ({we_l[3], c_l[3]} !== {1'b1, 16'd0}) begin
      fails++; $display("FAIL n1_write: got we=%b c=%0d expected we=1 c=0", we_l[3], c_l[3]);
    end
    checks++;
    if (done_at !== 4) begin fails++; $display("FAIL n1_done_cycle: got %0d expected 4", done_at); end
  endtask

  task automatic test_n0();
    run(8'd0, 64'h0, 0, 0, 4);
    checks++;
    if (clr_n + mac_n + we_n !== 0) begin
      fails++; $display("FAIL n0_strobes: got %0d expected 0", clr_n + mac_n + we_n);
    end
    checks++;
    if (done_at !== 1) begin fails++; $display("FAIL n0_done_cycle: got %0d expected 1", done_at); end
    checks++;
    if ({busy_l[1], busy_l[2], done_l[2]} !== 3'b100) begin
      fails++; $display("FAIL n0_busy_idle: got %b expected 100", {busy_l[1], busy_l[2], done_l[2]});
    end
  endtask

  task automatic test_stall();
    logic [63:0] mask;
    mask = '0;
    mask[3] = 1'b1; mask[4] = 1'b1; mask[5] = 1'b1; mask[7] = 1'b1;
    run(8'd2, mask, 0, 0, 25);
    checks++;
    if (done_at !== 21) begin fails++; $display("FAIL stall_done_cycle: got %0d expected 21", done_at); end
    for (int c = 3; c <= 5; c++) begin
      checks++;
      if ({mac_l[c], k_l[c], a_l[c], b_l[c]} !== {1'b0, 8'd1, 16'd1, 16'd2}) begin
        fails++; $display("FAIL stall_freeze[%0d]: got en=%b k=%0d a=%0d b=%0d expected en=0 k=1 a=1 b=2",
                          c, mac_l[c], k_l[c], a_l[c], b_l[c]);
      end
    end
    checks++;
    if ({mac_l[6], a_l[6], b_l[6]} !== {1'b1, 16'd1, 16'd2}) begin
      fails++; $display("FAIL stall_resume: got en=%b a=%0d b=%0d expected en=1 a=1 b=2",
                        mac_l[6], a_l[6], b_l[6]);
    end
    checks++;
    if ({we_l[7], we_l[8], c_l[7], c_l[8]} !== {2'b01, 16'd0, 16'd0}) begin
      fails++; $display("FAIL stall_write: got we7=%b we8=%b c7=%0d c8=%0d expected 0 1 0 0",
                        we_l[7], we_l[8], c_l[7], c_l[8]);
    end
    checks++;
    if ({mac_n, we_n} !== {32'd8, 32'd4}) begin
      fails++; $display("FAIL stall_counts: got mac=%0d we=%0d expected 8 4", mac_n, we_n);
    end
  endtask

  task automatic test_start_while_busy();
    run(8'd2, 64'h0, 3, 0, 25);
    checks++;
    if ({done_at, done_cnt} !== {32'd17, 32'd1}) begin
      fails++; $display("FAIL busy_start_done: got at=%0d cnt=%0d expected 17 1", done_at, done_cnt);
    end
    for (int c = 18; c <= 25; c++) begin
      checks++;
      if (busy_l[c] !== 1'b0) begin
        fails++; $display("FAIL busy_start_requeued[%0d]: got %b expected 0", c, busy_l[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    run(8'd3, 64'h0, 0, 6, 12);
    checks++;
    if ({busy_l[7], done_l[7], clr_l[7], mac_l[7], we_l[7]} !== 5'b0) begin
      fails++; $display("FAIL rstmid_strobes: got %b expected 0",
                        {busy_l[7], done_l[7], clr_l[7], mac_l[7], we_l[7]});
    end
    checks++;
    if ({a_l[7], b_l[7], c_l[7], i_l[7], j_l[7], k_l[7]} !== 72'h0) begin
      fails++; $display("FAIL rstmid_state: got a=%0d b=%0d c=%0d i=%0d j=%0d k=%0d expected 0",
                        a_l[7], b_l[7], c_l[7], i_l[7], j_l[7], k_l[7]);
    end
    checks++;
    if (done_cnt !== 0) begin fails++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    run(8'd1, 64'h0, 0, 0, 6);
    checks++;
    if ({done_at, we_n} !== {32'd4, 32'd1}) begin
      fails++; $display("FAIL rstmid_restart: got done=%0d we=%0d expected 4 1", done_at, we_n);
    end
  endtask

  task automatic test_wrap();
    int w_done_at;
    int max_idx;
    w_done_at = -1;
    max_idx = 0;
    w_n_dim = 8'd5;
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    for (int c = 1; c <= 180; c++) begin
      @(negedge clk);
      if (int'(w_i_idx) > max_idx) max_idx = int'(w_i_idx);
      if (int'(w_j_idx) > max_idx) max_idx = int'(w_j_idx);
      if (int'(w_k_idx) > max_idx) max_idx = int'(w_k_idx);
      if (w_done && w_done_at < 0) w_done_at = c;
      if (c == 6) begin
        checks++;
        if ({w_mac_en, w_addr_b} !== {1'b1, 4'd4}) begin
          fails++; $display("FAIL wrap_b_k4j0: got en=%b b=%0d expected en=1 b=4", w_mac_en, w_addr_b);
        end
      end
      if (c == 34) begin
        checks++;
        if ({w_mac_en, w_addr_b} !== {1'b1, 4'd8}) begin
          fails++; $display("FAIL wrap_b_k4j4: got en=%b b=%0d expected en=1 b=8", w_mac_en, w_addr_b);
        end
      end
      if (c == 174) begin
        checks++;
        if ({w_mac_en, w_addr_a} !== {1'b1, 4'd8}) begin
          fails++; $display("FAIL wrap_a_i4k4: got en=%b a=%0d expected en=1 a=8", w_mac_en, w_addr_a);
        end
      end
      if (c == 175) begin
        checks++;
        if ({w_c_we, w_addr_c} !== {1'b1, 4'd8}) begin
          fails++; $display("FAIL wrap_c_last: got we=%b c=%0d expected we=1 c=8", w_c_we, w_addr_c);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (w_done_at !== 176) begin
      fails++; $display("FAIL wrap_done_cycle: got %0d expected 176", w_done_at);
    end
    checks++;
    if (max_idx > 4) begin fails++; $display("FAIL wrap_idx_range: got max %0d expected <=4", max_idx); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_n1();
    test_n0();
    test_stall();
    test_start_while_busy();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
